lzc_share_arbiter: RTL and testbench
====================================

// Module: lzc_share_arbiter
// PURPOSE
//  Shares one LeadingZeroCounter_16b instance between NREQ requesters (posit decode of
//  operand A/B, normalisation after add/mul, ...). Each requester issues 16-bit words over
//  a valid/ready handshake. A round-robin arbiter picks one word per cycle and feeds it to
//  the LZC, optionally inverted so the LZC counts leading ones (regime run).
//  The result is registered and returned with the requester ID.
//  Multi-word bursts (req_last=0) lock the LZC to one owner until the burst ends.
// PARAMETERS
//  NREQ  4  number of requesters (2..8)
//  IDW   2  requester ID width; must be >= clog2(NREQ)
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  req_valid  in   NREQ     per-requester word valid
//  req_ready  out  NREQ     per-requester accept (one-hot or zero)
//  req_data   in   16*NREQ  word i on bits [16*i+15:16*i]
//  req_inv    in   NREQ     1 = invert word before LZC (count leading ones)
//  req_last   in   NREQ     1 = last word of burst; 0 = keep grant locked
//  rsp_valid  out  1        result valid
//  rsp_ready  in   1        consumer accepts result
//  rsp_id     out  IDW      requester that issued the word
//  rsp_count  out  4        leading-zero count of operand, 0..15
//  rsp_zero   out  1        operand was all-zero (LZC Q flag)
// BEHAVIOUR
//  - Reset (async, rst_n=0): rsp_valid=0, rsp_id=0, rsp_count=0, rsp_zero=0, state=IDLE,
//    rr_ptr=NREQ-1 (requester 0 wins first), owner=0. Reset mid-burst drops the lock and
//    discards the pending result.
//  - Operand = req_inv[g] ? ~req_data[g] : req_data[g], where g is the granted index.
//    Operand 0x0000 -> count=15, zero=1. Any other operand -> count = number of leading
//    zeros, zero=0.
//  - slot_free = !rsp_valid | rsp_ready. Only the granted requester sees
//    req_ready[g] = req_valid[g] & slot_free. req_ready depends combinationally on
//    rsp_ready; there is no other combinational path.
//  - Accept occurs on a rising edge when req_valid[g] & req_ready[g]. At that edge,
//    rsp_* load {g, count, zero} and rsp_valid=1. Latency is 1 cycle.
//    Throughput is 1 word/cycle when rsp_ready is held at 1.
//  - If there is no accept and rsp_valid & rsp_ready, then rsp_valid goes to 0.
//    While rsp_valid & !rsp_ready, the rsp_* outputs hold stable.
//  - State IDLE: g = first i with req_valid[i], searching rr_ptr+1, rr_ptr+2, ... mod NREQ.
//    On accept with req_last[g]=1: rr_ptr<=g and state stays IDLE.
//    On accept with req_last[g]=0: owner<=g and state goes to LOCKED.
//  - State LOCKED: g = owner. Other requesters get req_ready=0 even if the owner is idle.
//    On accept with req_last=1: rr_ptr<=owner and state goes to IDLE.
//  - No valid requester in IDLE: no grant, all req_ready=0, rr_ptr unchanged.
//  - A requester must hold valid/data/inv/last stable until accepted.
//    The arbiter never drops an offered word.
//  - Grant in IDLE is recomputed every cycle. A stalled (slot-full) winner can be
//    pre-empted by rotation only after an accept; rr_ptr changes only on accept.
// TESTING
//  - Reset, then req_valid=0001, data0=0x00F0, inv=0, last=1, rsp_ready=1 ->
//    one cycle later rsp_valid=1, id=0, count=8, zero=0.
//  - Word 0x0000 -> count=15, zero=1. Word 0xC000 with inv=1 -> operand 0x3FFF,
//    count=2, zero=0.
//  - req_valid=1111 held, all last=1, rsp_ready=1 -> ids 0,1,2,3,0,... on consecutive
//    cycles with no bubbles.
//  - Req1 burst of 3 words (last=0,0,1) while req0/req2 stay valid -> ids 1,1,1.
//    Then IDLE rotation continues with id 2 first.
//  - rsp_ready=0 for 4 cycles with result pending -> rsp_* stable, all req_ready=0.
//    Release -> next word accepted in the same cycle rsp_ready returns to 1.
//  - Assert rst_n=0 mid-burst while LOCKED -> rsp_valid=0 immediately.
//    After release, requester 0 wins even if the old owner is still valid.

Source files
------------

// File: rtl/lzc_share_arbiter.sv
// Round-robin arbiter sharing one 16-bit leading-zero counter between NREQ requesters.
// Bursts (req_last=0) lock the grant to one owner; the result is registered with the requester ID.
module lzc_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]      req_inv,
  input  logic [NREQ-1:0]      req_last,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [3:0]           rsp_count,
  output logic                 rsp_zero
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_reg;
  logic [IDW-1:0]  rr_ptr_reg;
  logic [IDW-1:0]  owner_reg;
  logic            rsp_valid_reg;
  logic [IDW-1:0]  rsp_id_reg;
  logic [3:0]      rsp_count_reg;
  logic            rsp_zero_reg;

  logic [15:0]     word [NREQ];
  logic [IDW-1:0]  cand [NREQ];
  logic [NREQ-1:0] cand_valid;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_idx;
  logic            slot_free;
  logic            accept;
  logic [15:0]     operand;
  logic [3:0]      lzc_cnt;
  logic            lzc_zero;

  // cand[k] is the (k+1)-th requester after rr_ptr in round-robin order.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      logic [IDW:0] sum;
      assign word[gi]       = req_data[16*gi +: 16];
      assign sum            = {1'b0, rr_ptr_reg} + (IDW+1)'(gi + 1);
      assign cand[gi]       = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
      assign cand_valid[gi] = req_valid[cand[gi]];
      assign req_ready[gi]  = gnt_any && (gnt_idx == IDW'(gi)) && req_valid[gi] && slot_free;
    end
  endgenerate

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (state_reg == LOCKED) begin
      gnt_any = 1'b1;
      gnt_idx = owner_reg;
    end else begin
      // Descending scan so the nearest candidate after rr_ptr is the last assignment.
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (cand_valid[k]) begin
          gnt_any = 1'b1;
          gnt_idx = cand[k];
        end
      end
    end
  end

  assign slot_free = !rsp_valid_reg || rsp_ready;
  assign accept    = |req_ready;
  assign operand   = req_inv[gnt_idx] ? ~word[gnt_idx] : word[gnt_idx];

  // All-zero operand reports 15 with the zero flag; the highest set bit otherwise wins.
  always_comb begin
    lzc_cnt  = 4'd15;
    lzc_zero = 1'b1;
    for (int b = 0; b < 16; b++) begin
      if (operand[b]) begin
        lzc_cnt  = 4'(15 - b);
        lzc_zero = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= IDW'(NREQ - 1);
      owner_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_count_reg <= '0;
      rsp_zero_reg  <= 1'b0;
    end else begin
      if (accept) begin
        rsp_valid_reg <= 1'b1;
        rsp_id_reg    <= gnt_idx;
        rsp_count_reg <= lzc_cnt;
        rsp_zero_reg  <= lzc_zero;
        if (req_last[gnt_idx]) begin
          rr_ptr_reg <= gnt_idx;
          state_reg  <= IDLE;
        end else begin
          owner_reg  <= gnt_idx;
          state_reg  <= LOCKED;
        end
      end else if (rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_count = rsp_count_reg;
  assign rsp_zero  = rsp_zero_reg;

endmodule

// File: tb/tb_lzc_share_arbiter.sv
// Bench for lzc_share_arbiter: directed cases with literal expectations, then randomized traffic
// checked every cycle against a behavioural model of the arbitration and counting rules.
module tb_lzc_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [16*NREQ-1:0]  req_data = '0;
  logic [NREQ-1:0]     req_inv = '0;
  logic [NREQ-1:0]     req_last = '1;
  logic                rsp_valid;
  logic                rsp_ready = 1'b1;
  logic [IDW-1:0]      rsp_id;
  logic [3:0]          rsp_count;
  logic                rsp_zero;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int              m_rr = NREQ - 1;
  int              m_owner = 0;
  bit              m_locked = 0;
  bit              m_valid = 0;
  int              m_id = 0;
  int              m_cnt = 0;
  bit              m_zero = 0;
  logic [NREQ-1:0] exp_ready = '0;
  logic [NREQ-1:0] last_acc = '0;
  bit              chk_en = 0;

  // Random-phase requester state
  bit          pv [NREQ];
  logic [15:0] pd [NREQ];
  bit          pinv [NREQ];
  bit          plast [NREQ];

  lzc_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_inv   (req_inv),
    .req_last  (req_last),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .rsp_zero  (rsp_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_lzc(input logic [15:0] op, output int cnt, output bit z);
    cnt = 0;
    while (cnt < 16 && op[15 - cnt] == 1'b0) cnt++;
    z = (cnt == 16);
    if (z) cnt = 15;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    logic [NREQ-1:0] r;
    bit free;
    int i;
    r = '0;
    free = !m_valid || rsp_ready;
    if (m_locked) begin
      if (req_valid[m_owner] && free) r[m_owner] = 1'b1;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        i = (m_rr + k) % NREQ;
        if (req_valid[i]) begin
          if (free) r[i] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  // One clock cycle: inputs are already driven; predict, cross the edge, advance the model.
  task automatic step();
    logic [NREQ-1:0] acc;
    logic [15:0]     op;
    int              g;
    int              cnt;
    bit              z;
    exp_ready = model_ready();
    acc = exp_ready;
    g = 0;
    @(posedge clk);
    if (acc != '0) begin
      for (int i = 0; i < NREQ; i++) if (acc[i]) g = i;
      op = req_data[16*g +: 16];
      if (req_inv[g]) op = ~op;
      model_lzc(op, cnt, z);
      m_valid = 1;
      m_id    = g;
      m_cnt   = cnt;
      m_zero  = z;
      if (req_last[g]) begin
        m_rr = g;
        m_locked = 0;
      end else begin
        m_owner = g;
        m_locked = 1;
      end
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    last_acc = acc;
    #1;
  endtask

  task automatic do_reset(input string tag);
    chk_en = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_valid"}, rsp_valid, 0);
    chk({tag, "_rst_id"}, rsp_id, 0);
    chk({tag, "_rst_count"}, rsp_count, 0);
    chk({tag, "_rst_zero"}, rsp_zero, 0);
    m_valid = 0; m_rr = NREQ - 1; m_locked = 0; m_owner = 0;
    m_id = 0; m_cnt = 0; m_zero = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, exp_ready);
      chk("rsp_valid", rsp_valid, m_valid);
      if (m_valid) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_count", rsp_count, m_cnt);
        chk("rsp_zero", rsp_zero, m_zero);
      end
    end
  end

  initial begin
    do_reset("init");

    // Single words from requester 0
    req_valid = 4'b0001; req_data[15:0] = 16'h00F0; req_inv = '0; req_last = '1; rsp_ready = 1'b1;
    step();
    chk("t1_valid", rsp_valid, 1); chk("t1_id", rsp_id, 0);
    chk("t1_count", rsp_count, 8); chk("t1_zero", rsp_zero, 0);
    req_data[15:0] = 16'h0000;
    step();
    chk("t2_count", rsp_count, 15); chk("t2_zero", rsp_zero, 1);
    req_data[15:0] = 16'hC000; req_inv[0] = 1'b1;
    step();
    chk("t3_count", rsp_count, 2); chk("t3_zero", rsp_zero, 0);
    req_inv = '0;

    // Round robin with all requesters valid
    do_reset("rr");
    req_valid = '1; req_last = '1;
    req_data = {16'h0008, 16'h0040, 16'h0200, 16'h1000};
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_valid", rsp_valid, 1);
      chk("rr_id", rsp_id, k % NREQ);
    end

    // Burst of three words from requester 1 while 0 and 2 remain valid
    req_valid = 4'b0111; req_last = 4'b1101;
    step(); chk("burst_id0", rsp_id, 1);
    step(); chk("burst_id1", rsp_id, 1);
    req_last[1] = 1'b1;
    step(); chk("burst_id2", rsp_id, 1);
    req_valid[1] = 1'b0;
    step(); chk("post_burst_id", rsp_id, 2);
    step(); chk("post_burst_id2", rsp_id, 0);

    // Consumer stall with a result pending
    rsp_ready = 1'b0; req_valid = 4'b1000; req_data[63:48] = 16'h0100; req_last = '1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stall_valid", rsp_valid, 1);
      chk("stall_id", rsp_id, 0);
      chk("stall_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    chk("release_id", rsp_id, 3); chk("release_count", rsp_count, 7);
    req_valid = '0;
    step();

    // Reset while locked
    do_reset("mb");
    req_valid = 4'b0100; req_last = 4'b1011; req_data[47:32] = 16'h8000;
    step(); chk("mb_id", rsp_id, 2); chk("mb_count", rsp_count, 0);
    req_valid = 4'b0101; req_data[15:0] = 16'h0010;
    step(); chk("mb_id2", rsp_id, 2);
    do_reset("mb2");
    step(); chk("after_rst_id", rsp_id, 0); chk("after_rst_count", rsp_count, 11);

    // Randomized traffic
    req_valid = '0; req_last = '1; req_inv = '0;
    for (int i = 0; i < NREQ; i++) pv[i] = 0;
    step();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pv[i] && last_acc[i]) pv[i] = 0;
        if (!pv[i] && $urandom_range(1, 0) == 1) begin
          pv[i] = 1;
          case ($urandom_range(7, 0))
            0: pd[i] = 16'h0000;
            1: pd[i] = 16'hFFFF;
            default: pd[i] = 16'($urandom >> $urandom_range(31, 16));
          endcase
          pinv[i]  = ($urandom_range(3, 0) == 0);
          plast[i] = ($urandom_range(3, 0) != 0);
        end
        req_valid[i] = pv[i];
        req_data[16*i +: 16] = pd[i];
        req_inv[i] = pinv[i];
        req_last[i] = plast[i];
      end
      rsp_ready = ($urandom_range(3, 0) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
